// File: rtl/noc_pkg.sv
// Shared NoC definitions: port directions, packet attributes, header field layout.
package noc_pkg;

  localparam int unsigned NOC_PORTS  = 5;
  localparam int unsigned PORT_IDX_W = 3;

  // Header fields are COORD_W wide; offsets are field index times COORD_W.
  localparam int unsigned HDR_DEST_X_FIELD = 0;
  localparam int unsigned HDR_DEST_Y_FIELD = 1;

  typedef enum logic [2:0] {
    DIR_LOCAL = 3'd0,
    DIR_NORTH = 3'd1,
    DIR_SOUTH = 3'd2,
    DIR_EAST  = 3'd3,
    DIR_WEST  = 3'd4
  } direction_t;

  typedef enum logic [1:0] {
    PKT_DATA = 2'd0,
    PKT_REQ  = 2'd1,
    PKT_RESP = 2'd2,
    PKT_CTRL = 2'd3
  } pkt_type_t;

  typedef enum logic [1:0] {
    QOS_LOW    = 2'd0,
    QOS_NORMAL = 2'd1,
    QOS_HIGH   = 2'd2,
    QOS_URGENT = 2'd3
  } qos_level_t;

  // Next port index, wrapping at NOC_PORTS.
  function automatic logic [PORT_IDX_W-1:0] rr_next(input logic [PORT_IDX_W-1:0] idx);
    return (idx == PORT_IDX_W'(NOC_PORTS - 1)) ? '0 : idx + PORT_IDX_W'(1);
  endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Circular-buffer flit FIFO; pushes into a full buffer are dropped, head is combinational.
module noc_flit_fifo #(
  parameter int unsigned WIDTH = 288,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_c,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Fullness is judged on the registered count, so a same-cycle pop never frees a slot.
  always_comb begin
    do_push  = push_i && (count_q != CNT_W'(DEPTH));
    do_pop   = pop_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_c = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/noc_router_xy.sv
// 5-port XY mesh router: input FIFOs, per-output round-robin arbitration, registered outputs.
module noc_router_xy
  import noc_pkg::*;
#(
  parameter int unsigned FLIT_W      = 288,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned COORD_W     = 4,
  parameter int unsigned X_COORD     = 0,
  parameter int unsigned Y_COORD     = 0,
  parameter int unsigned MESH_SIZE_X = 4,
  parameter int unsigned MESH_SIZE_Y = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [NOC_PORTS-1:0][FLIT_W-1:0]            flit_in,
  input  logic [NOC_PORTS-1:0]                        valid_in,
  output logic [NOC_PORTS-1:0]                        ready_out,
  output logic [NOC_PORTS-1:0][FLIT_W-1:0]            flit_out,
  output logic [NOC_PORTS-1:0]                        valid_out,
  input  logic [NOC_PORTS-1:0]                        ready_in,
  output logic [31:0]                                 packets_routed,
  output logic [NOC_PORTS-1:0][$clog2(FIFO_DEPTH):0]  buffer_occupancy,
  output logic                                        congestion_detected
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned DX_LSB = HDR_DEST_X_FIELD * COORD_W;
  localparam int unsigned DY_LSB = HDR_DEST_Y_FIELD * COORD_W;

  if (FLIT_W < 2 * COORD_W || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      X_COORD >= MESH_SIZE_X || Y_COORD >= MESH_SIZE_Y) begin : g_param_check
    $error("noc_router_xy: illegal parameter combination");
  end

  logic [NOC_PORTS-1:0][FLIT_W-1:0]           head_c;
  logic [NOC_PORTS-1:0][CNT_W-1:0]            count;
  logic [NOC_PORTS-1:0]                       full_c;
  logic [NOC_PORTS-1:0]                       pop_c;
  direction_t                                 route_c [NOC_PORTS];
  logic [NOC_PORTS-1:0][NOC_PORTS-1:0]        req_c;   // [output][input]

  logic [NOC_PORTS-1:0][FLIT_W-1:0]           flit_q, flit_d;
  logic [NOC_PORTS-1:0]                       valid_q, valid_d;
  logic [NOC_PORTS-1:0][PORT_IDX_W-1:0]       ptr_q, ptr_d;
  logic [31:0]                                routed_q, routed_d;

  for (genvar p = 0; p < NOC_PORTS; p++) begin : g_fifo
    noc_flit_fifo #(
      .WIDTH (FLIT_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (valid_in[p]),
      .wdata_i (flit_in[p]),
      .pop_i   (pop_c[p]),
      .rdata_c (head_c[p]),
      .count_o (count[p])
    );
  end

  // Dimension-order routing: resolve X first, then Y.
  function automatic direction_t xy_route(input logic [COORD_W-1:0] dx,
                                          input logic [COORD_W-1:0] dy);
    if (dx > COORD_W'(X_COORD)) return DIR_EAST;
    if (dx < COORD_W'(X_COORD)) return DIR_WEST;
    if (dy > COORD_W'(Y_COORD)) return DIR_SOUTH;
    if (dy < COORD_W'(Y_COORD)) return DIR_NORTH;
    return DIR_LOCAL;
  endfunction

  always_comb begin
    req_c = '0;
    for (int p = 0; p < NOC_PORTS; p++) begin
      full_c[p]  = (count[p] == CNT_W'(FIFO_DEPTH));
      route_c[p] = xy_route(head_c[p][DX_LSB +: COORD_W], head_c[p][DY_LSB +: COORD_W]);
      if (count[p] != '0) req_c[route_c[p]][p] = 1'b1;
    end
  end

  // Per-output round-robin grant; a held output neither grants nor moves its pointer.
  always_comb begin
    logic                  found;
    logic [PORT_IDX_W-1:0] idx;
    logic [PORT_IDX_W-1:0] win;
    flit_d   = flit_q;
    valid_d  = valid_q;
    ptr_d    = ptr_q;
    pop_c    = '0;
    routed_d = routed_q;
    found    = 1'b0;
    idx      = '0;
    win      = '0;
    for (int o = 0; o < NOC_PORTS; o++) begin
      routed_d = routed_d + 32'(valid_q[o] & ready_in[o]);
      if (!valid_q[o] || ready_in[o]) begin
        found = 1'b0;
        win   = '0;
        idx   = ptr_q[o];
        for (int k = 0; k < NOC_PORTS; k++) begin
          if (!found && req_c[o][idx]) begin
            found = 1'b1;
            win   = idx;
          end
          idx = rr_next(idx);
        end
        if (found) begin
          flit_d[o]  = head_c[win];
          valid_d[o] = 1'b1;
          ptr_d[o]   = rr_next(win);
          pop_c[win] = 1'b1;
        end else begin
          valid_d[o] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flit_q   <= '0;
      valid_q  <= '0;
      ptr_q    <= '0;
      routed_q <= '0;
    end else begin
      flit_q   <= flit_d;
      valid_q  <= valid_d;
      ptr_q    <= ptr_d;
      routed_q <= routed_d;
    end
  end

  assign flit_out            = flit_q;
  assign valid_out           = valid_q;
  assign packets_routed      = routed_q;
  assign buffer_occupancy    = count;
  assign ready_out           = ~full_c;
  assign congestion_detected = |full_c;

endmodule
